// File: rtl/bus_decoder_pkg.sv
// ---------------------------------------------------------------------------
// bus_decoder_pkg
// Shared types for the agent-side Avalon-MM fan-out: word/byteenable widths,
// the agent select encoding, the decoder FSM states and a helper that turns
// a select value into a one-hot agent mask (all zero for SEL_NONE).
// ---------------------------------------------------------------------------
package bus_decoder_pkg;

    localparam int NUM_AGENTS = 3;
    localparam int WORD_W     = 32;
    localparam int BE_W       = WORD_W / 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BE_W-1:0]   byteen_t;

    typedef enum logic [1:0] {
        SEL_A0   = 2'd0,
        SEL_A1   = 2'd1,
        SEL_A2   = 2'd2,
        SEL_NONE = 2'd3
    } sel_t;

    typedef enum logic {
        IDLE         = 1'b0,
        READ_PENDING = 1'b1
    } dec_state_t;

    // One-hot agent mask; SEL_NONE selects nobody so every AND-OR mux
    // built from it collapses to zero for unmapped addresses.
    function automatic logic [NUM_AGENTS-1:0] sel_onehot(input sel_t sel);
        logic [NUM_AGENTS-1:0] hot;
        hot = '0;
        case (sel)
            SEL_A0:  hot = 3'b001;
            SEL_A1:  hot = 3'b010;
            SEL_A2:  hot = 3'b100;
            default: hot = 3'b000;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/bus_decoder_address_decoder.sv
// ---------------------------------------------------------------------------
// address_decoder
// Purely combinational address window decoder. A window hits when
// (address & MASK) == BASE; overlapping windows resolve to the lowest index.
// Ports:
//   address  in   bus address to decode
//   sel      out  selected agent, SEL_NONE when no window hits
// ---------------------------------------------------------------------------
module address_decoder
    import bus_decoder_pkg::*;
#(
    parameter logic [31:0] AGENT0_BASE = 32'h0000_0000,
    parameter logic [31:0] AGENT1_BASE = 32'h1000_0000,
    parameter logic [31:0] AGENT2_BASE = 32'h2000_0000,
    parameter logic [31:0] AGENT0_MASK = 32'hF000_0000,
    parameter logic [31:0] AGENT1_MASK = 32'hF000_0000,
    parameter logic [31:0] AGENT2_MASK = 32'hF000_0000
) (
    input  logic [WORD_W-1:0] address,
    output sel_t              sel
);

    always_comb begin
        sel = SEL_NONE;
        if ((address & AGENT0_MASK) == AGENT0_BASE) begin
            sel = SEL_A0;
        end else if ((address & AGENT1_MASK) == AGENT1_BASE) begin
            sel = SEL_A1;
        end else if ((address & AGENT2_MASK) == AGENT2_BASE) begin
            sel = SEL_A2;
        end
    end

endmodule

// File: rtl/bus_decoder.sv
// ---------------------------------------------------------------------------
// bus_decoder
// Single-host to three-agent Avalon-MM fan-out. Commands are routed
// combinationally to the agent whose window matches the address; the one
// outstanding read is tracked so its response returns from the right agent.
// Unmapped writes are acknowledged and dropped, unmapped reads are answered
// with DEFAULT_RDATA one cycle after acceptance.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   bus_*                       upstream agent port (from the CrossBar)
//     address/byteenable/read/write/host_to_agent in
//     agent_to_host/waitrequest/readdatavalid     out
//   agent_*[n]                  downstream host ports, one slice per agent
//     address/byteenable/read/write/host_to_agent out
//     agent_to_host/waitrequest/readdatavalid     in
// ---------------------------------------------------------------------------
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter logic [31:0] AGENT0_BASE   = 32'h0000_0000,
    parameter logic [31:0] AGENT1_BASE   = 32'h1000_0000,
    parameter logic [31:0] AGENT2_BASE   = 32'h2000_0000,
    parameter logic [31:0] AGENT0_MASK   = 32'hF000_0000,
    parameter logic [31:0] AGENT1_MASK   = 32'hF000_0000,
    parameter logic [31:0] AGENT2_MASK   = 32'hF000_0000,
    parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [WORD_W-1:0]                    bus_address,
    input  logic [BE_W-1:0]                      bus_byteenable,
    input  logic                                 bus_read,
    input  logic                                 bus_write,
    input  logic [WORD_W-1:0]                    bus_host_to_agent,
    output logic [WORD_W-1:0]                    bus_agent_to_host,
    output logic                                 bus_waitrequest,
    output logic                                 bus_readdatavalid,
    output logic [NUM_AGENTS-1:0][WORD_W-1:0]    agent_address,
    output logic [NUM_AGENTS-1:0][BE_W-1:0]      agent_byteenable,
    output logic [NUM_AGENTS-1:0]                agent_read,
    output logic [NUM_AGENTS-1:0]                agent_write,
    output logic [NUM_AGENTS-1:0][WORD_W-1:0]    agent_host_to_agent,
    input  logic [NUM_AGENTS-1:0][WORD_W-1:0]    agent_agent_to_host,
    input  logic [NUM_AGENTS-1:0]                agent_waitrequest,
    input  logic [NUM_AGENTS-1:0]                agent_readdatavalid
);

    sel_t                  live_sel;
    sel_t                  sel;
    sel_t                  sel_next;
    dec_state_t            state;
    dec_state_t            state_next;
    logic [NUM_AGENTS-1:0] live_hot;
    logic [NUM_AGENTS-1:0] pend_hot;
    logic                  cmd_wait;

    address_decoder #(
        .AGENT0_BASE (AGENT0_BASE),
        .AGENT1_BASE (AGENT1_BASE),
        .AGENT2_BASE (AGENT2_BASE),
        .AGENT0_MASK (AGENT0_MASK),
        .AGENT1_MASK (AGENT1_MASK),
        .AGENT2_MASK (AGENT2_MASK)
    ) u_address_decoder (
        .address (bus_address),
        .sel     (live_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= SEL_NONE;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    // Next state, strobe gating and response mux. Reset is folded in here
    // as well so outputs show their reset values for as long as reset is
    // held, not only from the next clock edge.
    always_comb begin
        state_next          = state;
        sel_next            = sel;
        agent_address       = '0;
        agent_byteenable    = '0;
        agent_read          = '0;
        agent_write         = '0;
        agent_host_to_agent = '0;
        bus_waitrequest     = 1'b1;
        bus_readdatavalid   = 1'b0;
        bus_agent_to_host   = '0;
        cmd_wait            = 1'b0;
        live_hot            = sel_onehot(live_sel);
        pend_hot            = sel_onehot(sel);

        if (!reset) begin
            case (state)
                IDLE: begin
                    // A simultaneous read and write keeps only the read.
                    for (int i = 0; i < NUM_AGENTS; i++) begin
                        if (live_hot[i]) begin
                            agent_address[i]       = bus_address;
                            agent_byteenable[i]    = bus_byteenable;
                            agent_host_to_agent[i] = bus_host_to_agent;
                            agent_read[i]          = bus_read;
                            agent_write[i]         = bus_write && !bus_read;
                        end
                    end
                    // Unmapped commands see no waitrequest since live_hot is zero.
                    cmd_wait        = (bus_read || bus_write) && |(live_hot & agent_waitrequest);
                    bus_waitrequest = cmd_wait;

                    if (bus_read && !cmd_wait) begin
                        if (|(live_hot & agent_readdatavalid)) begin
                            bus_readdatavalid = 1'b1;
                            for (int i = 0; i < NUM_AGENTS; i++) begin
                                if (live_hot[i]) begin
                                    bus_agent_to_host = agent_agent_to_host[i];
                                end
                            end
                        end else begin
                            sel_next   = live_sel;
                            state_next = READ_PENDING;
                        end
                    end
                end

                READ_PENDING: begin
                    if (sel == SEL_NONE) begin
                        bus_readdatavalid = 1'b1;
                        bus_agent_to_host = DEFAULT_RDATA;
                    end else begin
                        bus_readdatavalid = |(pend_hot & agent_readdatavalid);
                        for (int i = 0; i < NUM_AGENTS; i++) begin
                            if (pend_hot[i] && agent_readdatavalid[i]) begin
                                bus_agent_to_host = agent_agent_to_host[i];
                            end
                        end
                    end
                    if (bus_readdatavalid) begin
                        state_next = IDLE;
                        sel_next   = SEL_NONE;
                    end
                end

                default: begin
                    state_next = IDLE;
                    sel_next   = SEL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// ---------------------------------------------------------------------------
// tb_bus_decoder
// Directed plus randomized bench for bus_decoder. Agents are played by the
// bench itself; expected routing comes from a first-match window table and
// expected timing from the transaction shape (wait cycles, read latency).
// A second instance with agent1 overlapping agent0 checks decode priority.
// ---------------------------------------------------------------------------
module tb_bus_decoder;

    logic              clk;
    logic              reset;
    logic [31:0]       bus_address;
    logic [3:0]        bus_byteenable;
    logic              bus_read;
    logic              bus_write;
    logic [31:0]       bus_host_to_agent;
    logic [31:0]       bus_agent_to_host;
    logic              bus_waitrequest;
    logic              bus_readdatavalid;
    logic [2:0][31:0]  agent_address;
    logic [2:0][3:0]   agent_byteenable;
    logic [2:0]        agent_read;
    logic [2:0]        agent_write;
    logic [2:0][31:0]  agent_host_to_agent;
    logic [2:0][31:0]  agent_agent_to_host;
    logic [2:0]        agent_waitrequest;
    logic [2:0]        agent_readdatavalid;

    logic [31:0]       ovl_bus_agent_to_host;
    logic              ovl_bus_waitrequest;
    logic              ovl_bus_readdatavalid;
    logic [2:0][31:0]  ovl_agent_address;
    logic [2:0][3:0]   ovl_agent_byteenable;
    logic [2:0]        ovl_agent_read;
    logic [2:0]        ovl_agent_write;
    logic [2:0][31:0]  ovl_agent_host_to_agent;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] DEF_RDATA = 32'hDEAD_BEEF;

    bus_decoder dut (
        .clk                 (clk),
        .reset               (reset),
        .bus_address         (bus_address),
        .bus_byteenable      (bus_byteenable),
        .bus_read            (bus_read),
        .bus_write           (bus_write),
        .bus_host_to_agent   (bus_host_to_agent),
        .bus_agent_to_host   (bus_agent_to_host),
        .bus_waitrequest     (bus_waitrequest),
        .bus_readdatavalid   (bus_readdatavalid),
        .agent_address       (agent_address),
        .agent_byteenable    (agent_byteenable),
        .agent_read          (agent_read),
        .agent_write         (agent_write),
        .agent_host_to_agent (agent_host_to_agent),
        .agent_agent_to_host (agent_agent_to_host),
        .agent_waitrequest   (agent_waitrequest),
        .agent_readdatavalid (agent_readdatavalid)
    );

    bus_decoder #(
        .AGENT1_BASE (32'h0000_0000),
        .AGENT1_MASK (32'hF000_0000)
    ) dut_ovl (
        .clk                 (clk),
        .reset               (reset),
        .bus_address         (bus_address),
        .bus_byteenable      (bus_byteenable),
        .bus_read            (bus_read),
        .bus_write           (bus_write),
        .bus_host_to_agent   (bus_host_to_agent),
        .bus_agent_to_host   (ovl_bus_agent_to_host),
        .bus_waitrequest     (ovl_bus_waitrequest),
        .bus_readdatavalid   (ovl_bus_readdatavalid),
        .agent_address       (ovl_agent_address),
        .agent_byteenable    (ovl_agent_byteenable),
        .agent_read          (ovl_agent_read),
        .agent_write         (ovl_agent_write),
        .agent_host_to_agent (ovl_agent_host_to_agent),
        .agent_agent_to_host (agent_agent_to_host),
        .agent_waitrequest   (agent_waitrequest),
        .agent_readdatavalid (agent_readdatavalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a broken design can never stall the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference window table: the first matching window wins, 3 means unmapped.
    function automatic int refTarget(input logic [31:0] addr);
        logic [31:0] bases [3];
        bases[0] = 32'h0000_0000;
        bases[1] = 32'h1000_0000;
        bases[2] = 32'h2000_0000;
        for (int i = 0; i < 3; i++) begin
            if ((addr & 32'hF000_0000) == bases[i]) return i;
        end
        return 3;
    endfunction

    function automatic logic [2:0] expHot(input int t);
        return (t < 3) ? 3'(1 << t) : 3'b000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        bus_read          = rd;
        bus_write         = wr;
        bus_address       = addr;
        bus_byteenable    = be;
        bus_host_to_agent = wdata;
    endtask

    task automatic randomAgentData();
        for (int i = 0; i < 3; i++) agent_agent_to_host[i] = $urandom;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Host write held until the target agent stops stalling.
    task automatic doWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                           input int waits, input string tag);
        int t;
        logic expWait;
        t = refTarget(addr);
        for (int cyc = 0; cyc <= waits; cyc++) begin
            applyStimulus(1'b0, 1'b1, addr, be, wdata);
            agent_waitrequest = 3'($urandom);
            if (t < 3) agent_waitrequest[t] = (cyc < waits);
            agent_readdatavalid = 3'($urandom);
            randomAgentData();
            #1;
            expWait = (t < 3) && (cyc < waits);
            checkOutput({tag, ".wait"}, 32'(bus_waitrequest), 32'(expWait));
            checkOutput({tag, ".wr"}, 32'(agent_write), 32'(expHot(t)));
            checkOutput({tag, ".rd"}, 32'(agent_read), 32'h0);
            checkOutput({tag, ".rdv"}, 32'(bus_readdatavalid), 32'h0);
            if (t < 3) begin
                checkOutput({tag, ".addr"}, agent_address[t], addr);
                checkOutput({tag, ".wdata"}, agent_host_to_agent[t], wdata);
                checkOutput({tag, ".be"}, 32'(agent_byteenable[t]), 32'(be));
                checkOutput({tag, ".other_addr"}, agent_address[(t + 1) % 3], 32'h0);
            end
            nextCycle();
            if (t == 3) break;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        agent_readdatavalid = '0;
    endtask

    // Host read; lat 0 means the agent answers in the acceptance cycle,
    // otherwise lat cycles after acceptance. Unmapped reads answer after 1.
    task automatic doRead(input logic [31:0] addr, input logic [3:0] be, input int waits, input int lat,
                          input logic [31:0] rdata, input logic alsoWrite, input string tag);
        int t;
        int effLat;
        logic immediate;
        logic expWait;
        logic lastCmd;
        logic [31:0] expData;
        t = refTarget(addr);
        immediate = (t < 3) && (lat == 0);
        for (int cyc = 0; cyc <= waits; cyc++) begin
            applyStimulus(1'b1, alsoWrite, addr, be, $urandom);
            agent_waitrequest = 3'($urandom);
            if (t < 3) agent_waitrequest[t] = (cyc < waits);
            lastCmd = (t == 3) || (cyc == waits);
            agent_readdatavalid = 3'($urandom) & ~expHot(t);
            randomAgentData();
            if (immediate && lastCmd) begin
                agent_readdatavalid[t] = 1'b1;
                agent_agent_to_host[t] = rdata;
            end
            #1;
            expWait = (t < 3) && (cyc < waits);
            checkOutput({tag, ".wait"}, 32'(bus_waitrequest), 32'(expWait));
            checkOutput({tag, ".rd"}, 32'(agent_read), 32'(expHot(t)));
            checkOutput({tag, ".wr"}, 32'(agent_write), 32'h0);
            checkOutput({tag, ".rdv_cmd"}, 32'(bus_readdatavalid), 32'(immediate && lastCmd));
            checkOutput({tag, ".data_cmd"}, bus_agent_to_host, (immediate && lastCmd) ? rdata : 32'h0);
            if (t < 3) begin
                checkOutput({tag, ".addr"}, agent_address[t], addr);
                checkOutput({tag, ".be"}, 32'(agent_byteenable[t]), 32'(be));
            end
            nextCycle();
            if (lastCmd) break;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        if (!immediate) begin
            effLat  = (t == 3) ? 1 : lat;
            expData = (t == 3) ? DEF_RDATA : rdata;
            for (int k = 1; k <= effLat; k++) begin
                agent_waitrequest   = 3'($urandom);
                agent_readdatavalid = 3'($urandom) & ~expHot(t);
                randomAgentData();
                if (t < 3 && k == effLat) begin
                    agent_readdatavalid[t] = 1'b1;
                    agent_agent_to_host[t] = rdata;
                end
                #1;
                checkOutput({tag, ".wait_pend"}, 32'(bus_waitrequest), 32'h1);
                checkOutput({tag, ".rd_pend"}, 32'(agent_read), 32'h0);
                checkOutput({tag, ".wr_pend"}, 32'(agent_write), 32'h0);
                checkOutput({tag, ".rdv_pend"}, 32'(bus_readdatavalid), 32'(k == effLat));
                checkOutput({tag, ".data_pend"}, bus_agent_to_host, (k == effLat) ? expData : 32'h0);
                nextCycle();
            end
        end
        agent_readdatavalid = '0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        agent_waitrequest   = '0;
        agent_readdatavalid = 3'b111;
        randomAgentData();
        #1;
        checkOutput("reset.wait", 32'(bus_waitrequest), 32'h1);
        checkOutput("reset.rdv", 32'(bus_readdatavalid), 32'h0);
        checkOutput("reset.data", bus_agent_to_host, 32'h0);
        checkOutput("reset.rd", 32'(agent_read), 32'h0);
        checkOutput("reset.wr", 32'(agent_write), 32'h0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        agent_readdatavalid = '0;
        nextCycle();

        // Overlapping windows: agent0 must win in the overlap instance.
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        agent_waitrequest = 3'b111;
        #1;
        checkOutput("ovl.rd", 32'(ovl_agent_read), 32'h1);
        checkOutput("ovl.main_rd", 32'(agent_read), 32'h1);
        nextCycle();
        doRead(32'h0000_0100, 4'hF, 0, 0, 32'hA5A5_0100, 1'b0, "ovl_read");

        $display("[TB] directed sequence");
        doWrite(32'h1000_0004, 32'hCAFE_F00D, 4'hF, 2, "wr_a1");
        doRead(32'h2000_0010, 4'hF, 0, 3, 32'h1234_5678, 1'b0, "rd_a2");
        doRead(32'h2000_0020, 4'hF, 0, 1, 32'h0BAD_CAFE, 1'b0, "rd_a2_b2b");
        doRead(32'h0000_0000, 4'hF, 0, 0, 32'h1111_2222, 1'b0, "rd_a0_zero");
        doRead(32'h0000_0004, 4'h3, 0, 0, 32'h3333_4444, 1'b0, "rd_a0_b2b");
        doRead(32'h5000_0000, 4'hF, 0, 0, 32'h0, 1'b0, "rd_none");
        doWrite(32'h5000_0000, 32'h5555_AAAA, 4'hF, 0, "wr_none");
        doRead(32'h1000_0008, 4'hF, 1, 2, 32'h7777_8888, 1'b1, "rd_wr_both");

        $display("[TB] randomized sequence");
        for (int n = 0; n < 40; n++) begin
            a  = {4'($urandom_range(0, 5)), 26'($urandom), 2'b00};
            be = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                doRead(a, be, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'b0, "rand_rd");
            else
                doWrite(a, $urandom, be, $urandom_range(0, 2), "rand_wr");
        end

        $display("[TB] reset during pending read");
        applyStimulus(1'b1, 1'b0, 32'h1000_0040, 4'hF, 32'h0);
        agent_waitrequest   = '0;
        agent_readdatavalid = '0;
        #1;
        checkOutput("rst_mid.accept_wait", 32'(bus_waitrequest), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        checkOutput("rst_mid.pend_wait", 32'(bus_waitrequest), 32'h1);
        nextCycle();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        #1;
        checkOutput("rst_mid.wait", 32'(bus_waitrequest), 32'h1);
        checkOutput("rst_mid.rd", 32'(agent_read), 32'h0);
        checkOutput("rst_mid.rdv", 32'(bus_readdatavalid), 32'h0);
        nextCycle();
        agent_readdatavalid    = 3'b010;
        agent_agent_to_host[1] = 32'h9999_9999;
        #1;
        checkOutput("rst_mid.late_rdv_held", 32'(bus_readdatavalid), 32'h0);
        checkOutput("rst_mid.late_data_held", bus_agent_to_host, 32'h0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        checkOutput("rst_mid.late_rdv_idle", 32'(bus_readdatavalid), 32'h0);
        checkOutput("rst_mid.late_data_idle", bus_agent_to_host, 32'h0);
        checkOutput("rst_mid.idle_wait", 32'(bus_waitrequest), 32'h0);
        nextCycle();
        agent_readdatavalid = '0;
        doRead(32'h1000_0044, 4'hF, 0, 2, 32'h4242_4242, 1'b0, "rd_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
